// File: rtl/instruction_fetch.sv
// Fetch stage: keeps the PC, issues one word read at a time and buffers
// returned words in a small skid FIFO feeding decode.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iq_full,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(BUF_DEPTH);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_DISCARD
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [31:0]   pc_q;
    logic [31:0]   req_pc_q;
    logic [AW:0]   count_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [31:0]   buf_pc   [BUF_DEPTH];
    logic [31:0]   buf_data [BUF_DEPTH];

    logic req_fire;
    logic push;
    logic pop;

    // A request is only issued when a FIFO slot is free, so the response
    // always has somewhere to land.
    assign mem_req_valid = (state_q == S_FETCH) && (count_q < FULL) && !redirect_valid;
    assign mem_req_addr  = pc_q;
    assign req_fire      = mem_req_valid && mem_req_ready;
    assign push          = (state_q == S_WAIT) && mem_resp_valid && !redirect_valid;
    assign pop           = (count_q != '0) && !iq_full && !redirect_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            if (state_q == S_FETCH || mem_resp_valid) begin
                state_d = S_FETCH;
            end else begin
                state_d = S_DISCARD;
            end
        end else begin
            unique case (state_q)
                S_FETCH:   if (req_fire) state_d = S_WAIT;
                S_WAIT:    if (mem_resp_valid) state_d = S_FETCH;
                S_DISCARD: if (mem_resp_valid) state_d = S_FETCH;
                default:   state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
        end else if (redirect_valid) begin
            pc_q <= redirect_pc & ~32'h3;
        end else if (req_fire) begin
            pc_q     <= pc_q + 32'd4;
            req_pc_q <= pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[wr_ptr_q]   <= req_pc_q;
            buf_data[wr_ptr_q] <= mem_resp_data;
        end
    end

    // inst/inst_pc keep their last value between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
        end else if (pop) begin
            inst_valid <= 1'b1;
            inst       <= buf_data[rd_ptr_q];
            inst_pc    <= buf_pc[rd_ptr_q];
        end else begin
            inst_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, hand sequences for
// redirect/reset corners, and random traffic against a stream model.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        iq_full;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic [31:0] w_resp_data;
    logic        w_inst_valid;
    logic [31:0] w_inst;
    logic [31:0] w_inst_pc;

    always #5 clk = ~clk;

    instruction_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .iq_full(iq_full),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data), .inst_valid(inst_valid),
        .inst(inst), .inst_pc(inst_pc)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) dut_wrap (
        .clk(clk), .rst(rst), .iq_full(iq_full),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req_valid(w_req_valid), .mem_req_addr(w_req_addr),
        .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(w_resp_data), .inst_valid(w_inst_valid),
        .inst(w_inst), .inst_pc(w_inst_pc)
    );

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    typedef struct {
        int          due;
        logic [31:0] d;
        logic [31:0] wd;
    } rsp_t;
    rsp_t pend[$];

    logic        last_req_v;
    logic [31:0] last_req_a;
    logic [31:0] last_w_a;

    // stream model state
    logic        model_on = 1'b0;
    logic [31:0] exp_pc;
    logic [31:0] exp_req;
    int          acc_n;
    int          del_n;
    int          del_total;
    logic        hold_v;
    logic [31:0] hold_a;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a << 5) + 32'h13;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick(input logic r, input logic iqf, input logic rv,
                        input logic [31:0] rpc, input logic rdy, input int lat);
        logic acc;
        rst            = r;
        iq_full        = iqf;
        redirect_valid = rv;
        redirect_pc    = rpc;
        mem_req_ready  = rdy;
        mem_resp_valid = 1'b0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = pend[0].d;
            w_resp_data    = pend[0].wd;
            void'(pend.pop_front());
        end
        #1;
        last_req_v = mem_req_valid;
        last_req_a = mem_req_addr;
        last_w_a   = w_req_addr;
        acc = mem_req_valid && rdy && !r;
        if (model_on) begin
            if (rv) chk("redirect_no_req", 32'(mem_req_valid), 32'd0);
            if (hold_v && !rv) begin
                chk("req_valid_hold", 32'(mem_req_valid), 32'd1);
                chk("req_addr_hold", mem_req_addr, hold_a);
            end
            hold_v = mem_req_valid && !rdy;
            hold_a = mem_req_addr;
            if (acc) begin
                chk("req_addr_seq", mem_req_addr, exp_req);
                chk("one_outstanding", 32'(pend.size()), 32'd0);
                chk("buf_bound", 32'(acc_n - del_n < 2), 32'd1);
                exp_req = exp_req + 32'd4;
                acc_n++;
            end
        end
        if (acc) pend.push_back('{due: cyc + lat, d: word_of(mem_req_addr), wd: word_of(w_req_addr)});
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (model_on) begin
            if (inst_valid) begin
                chk("model_pc", inst_pc, exp_pc);
                chk("model_inst", inst, word_of(inst_pc));
                chk("pop_when_blocked", 32'(iqf | rv), 32'd0);
                exp_pc = exp_pc + 32'd4;
                del_n++;
                del_total++;
            end
            if (rv) begin
                chk("redirect_kills_out", 32'(inst_valid), 32'd0);
                exp_pc  = rpc & ~32'h3;
                exp_req = rpc & ~32'h3;
                acc_n   = 0;
                del_n   = 0;
            end
        end
    endtask

    task automatic do_reset();
        pend.delete();
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1);
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_wrap_inst_pc", w_inst_pc, 32'd0);
    endtask

    typedef struct {
        logic        rs;
        logic        iqf;
        logic        e_rv;
        logic [31:0] e_ra;
        logic        e_iv;
        logic [31:0] e_pc;
    } vec_t;

    initial begin
        vec_t vt[17];
        logic [31:0] wpc;

        vt[0]  = '{1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0};
        vt[1]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
        vt[2]  = '{1'b0, 1'b0, 1'b1, 32'h4, 1'b1, 32'h0};
        vt[3]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
        vt[4]  = '{1'b0, 1'b0, 1'b1, 32'h8, 1'b1, 32'h4};
        vt[5]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
        vt[6]  = '{1'b0, 1'b0, 1'b1, 32'hC, 1'b1, 32'h8};
        vt[7]  = '{1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0};
        vt[8]  = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
        vt[9]  = '{1'b0, 1'b1, 1'b1, 32'h4, 1'b0, 32'h0};
        vt[10] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
        vt[11] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
        vt[12] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
        vt[13] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0};
        vt[14] = '{1'b0, 1'b0, 1'b1, 32'h8, 1'b1, 32'h4};
        vt[15] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
        vt[16] = '{1'b0, 1'b0, 1'b1, 32'hC, 1'b1, 32'h8};

        rst = 1'b1; iq_full = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        mem_resp_data = '0; w_resp_data = '0;
        @(negedge clk);

        // sequential fetch and iq_full backpressure; the wrap instance
        // runs in lockstep from RESET_PC=FFFF_FFF8
        foreach (vt[i]) begin
            if (vt[i].rs) do_reset();
            tick(1'b0, vt[i].iqf, 1'b0, 32'h0, 1'b1, 1);
            chk($sformatf("v%0d_req_valid", i), 32'(last_req_v), 32'(vt[i].e_rv));
            if (vt[i].e_rv) begin
                chk($sformatf("v%0d_req_addr", i), last_req_a, vt[i].e_ra);
                chk($sformatf("v%0d_wrap_req_addr", i), last_w_a, vt[i].e_ra + 32'hFFFF_FFF8);
            end
            chk($sformatf("v%0d_inst_valid", i), 32'(inst_valid), 32'(vt[i].e_iv));
            chk($sformatf("v%0d_wrap_inst_valid", i), 32'(w_inst_valid), 32'(vt[i].e_iv));
            if (vt[i].e_iv) begin
                wpc = vt[i].e_pc + 32'hFFFF_FFF8;
                chk($sformatf("v%0d_inst_pc", i), inst_pc, vt[i].e_pc);
                chk($sformatf("v%0d_inst", i), inst, word_of(vt[i].e_pc));
                chk($sformatf("v%0d_wrap_inst_pc", i), w_inst_pc, wpc);
                chk($sformatf("v%0d_wrap_inst", i), w_inst, word_of(wpc));
            end
        end

        // redirect while waiting; late response for 0x8 must vanish
        do_reset();
        repeat (4) tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 2);
        chk("t3_req_addr8", last_req_a, 32'h8);
        chk("t3_pc4", inst_pc, 32'h4);
        tick(1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 1);
        chk("t3_redir_req", 32'(last_req_v), 32'd0);
        chk("t3_redir_iv", 32'(inst_valid), 32'd0);
        chk("t3_inst_hold", inst, word_of(32'h4));
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1);
        chk("t3_discard_req", 32'(last_req_v), 32'd0);
        chk("t3_discard_iv", 32'(inst_valid), 32'd0);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1);
        chk("t3_new_req", last_req_a, 32'h200);
        chk("t3_new_req_v", 32'(last_req_v), 32'd1);
        chk("t3_iv_a", 32'(inst_valid), 32'd0);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1);
        chk("t3_iv_b", 32'(inst_valid), 32'd0);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1);
        chk("t3_iv_200", 32'(inst_valid), 32'd1);
        chk("t3_pc_200", inst_pc, 32'h200);
        chk("t3_inst_200", inst, word_of(32'h200));

        // misaligned redirect coinciding with a response
        do_reset();
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1);
        tick(1'b0, 1'b0, 1'b1, 32'h103, 1'b1, 1);
        chk("t4_redir_req", 32'(last_req_v), 32'd0);
        chk("t4_redir_iv", 32'(inst_valid), 32'd0);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1);
        chk("t4_req_v", 32'(last_req_v), 32'd1);
        chk("t4_req_addr", last_req_a, 32'h100);
        chk("t4_iv_a", 32'(inst_valid), 32'd0);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1);
        chk("t4_iv_b", 32'(inst_valid), 32'd0);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1);
        chk("t4_iv_100", 32'(inst_valid), 32'd1);
        chk("t4_pc_100", inst_pc, 32'h100);
        chk("t4_inst_100", inst, word_of(32'h100));

        // reset mid-transaction; stale response after reset is ignored
        do_reset();
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 3);
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1);
        chk("t6_rst_iv", 32'(inst_valid), 32'd0);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1);
        chk("t6_req_v", 32'(last_req_v), 32'd1);
        chk("t6_req_addr", last_req_a, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1);
        chk("t6_stale_iv", 32'(inst_valid), 32'd0);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1);
        chk("t6_iv_a", 32'(inst_valid), 32'd0);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1);
        chk("t6_iv_b", 32'(inst_valid), 32'd0);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1);
        chk("t6_iv", 32'(inst_valid), 32'd1);
        chk("t6_pc", inst_pc, 32'h0);
        chk("t6_inst", inst, word_of(32'h0));

        // random traffic against the stream model
        do_reset();
        exp_pc = 32'h0; exp_req = 32'h0;
        acc_n = 0; del_n = 0; del_total = 0;
        hold_v = 1'b0; hold_a = '0;
        model_on = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            logic        r_iqf;
            logic        r_rv;
            logic [31:0] r_pc;
            logic        r_rdy;
            r_iqf = ($urandom % 100) < 30;
            r_rv  = ($urandom % 100) < 3;
            r_pc  = ($urandom % 4 == 0) ? (32'hFFFF_FFE0 | ($urandom % 32)) : $urandom;
            r_rdy = ($urandom % 100) < 65;
            tick(1'b0, r_iqf, r_rv, r_pc, r_rdy, int'($urandom_range(1, 4)));
        end
        model_on = 1'b0;
        chk("liveness", 32'(del_total > 200), 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
